seg7_scan: RTL and testbench

Multiplexed hex seven-segment display driver for the lab board. It consumes the 1 ms clock-enable strobe from the system tick generator and drives one digit per strobe. Data is written through a shadow-register load port, and the displayed value changes only at frame boundaries, so no digit tears. It sits between user logic (counters, stopwatch) and the board's common-anode indicator pins.

---
 rtl/seg7_scan.sv | 147 ++++++++++++++
 tb/tb_seg7_scan.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// Multiplexed hex seven-segment scanner: shadow-register load port, frame-aligned
// transfer to the display register, one digit driven per 1 ms strobe.
module seg7_scan #(
  parameter int unsigned DIGITS     = 4,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ce1ms_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   data_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic                  blank_lz_i,
  output logic [6:0]            seg_o,
  output logic                  seg_dp_o,
  output logic [DIGITS-1:0]     an_o,
  output logic                  pend_o,
  output logic                  frame_o
);

  localparam int unsigned DW = 4 * DIGITS;
  localparam int unsigned IW = 3;
  localparam logic [IW-1:0]     LAST    = IW'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF = {7{ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{ACTIVE_LOW}};

  // Active-high {g,f,e,d,c,b,a} pattern for one hex nibble
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [DW-1:0]     shadow_data_q, shadow_data_d;
  logic [DIGITS-1:0] shadow_dp_q,   shadow_dp_d;
  logic [DW-1:0]     disp_data_q,   disp_data_d;
  logic [DIGITS-1:0] disp_dp_q,     disp_dp_d;
  logic              pend_q,        pend_d;
  logic [IW-1:0]     idx_q,         idx_d;
  logic [6:0]        seg_q,         seg_d;
  logic              seg_dp_q,      seg_dp_d;
  logic [DIGITS-1:0] an_q,          an_d;
  logic              frame_q,       frame_d;

  logic [IW-1:0]     nidx;
  logic              xfer;
  logic [DW-1:0]     src_data;
  logic [DIGITS-1:0] src_dp;
  logic [DW-1:0]     upper;
  logic              blank;
  logic [6:0]        seg_act;
  logic [DIGITS-1:0] an_act;
  logic              seg_dp_act;

  // Next-state: shadow load, frame-boundary transfer, per-strobe digit update
  always_comb begin
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    disp_data_d   = disp_data_q;
    disp_dp_d     = disp_dp_q;
    pend_d        = pend_q;
    idx_d         = idx_q;
    seg_d         = seg_q;
    seg_dp_d      = seg_dp_q;
    an_d          = an_q;
    frame_d       = 1'b0;

    nidx       = (idx_q == LAST) ? '0 : idx_q + IW'(1);
    xfer       = ce1ms_i && (nidx == '0) && pend_q;
    src_data   = xfer ? shadow_data_q : disp_data_q;
    src_dp     = xfer ? shadow_dp_q   : disp_dp_q;
    // Nibbles nidx and above; all-zero means this digit is a leading zero
    upper      = src_data >> {nidx, 2'b00};
    blank      = blank_lz_i && (nidx != '0) && (upper == '0);
    seg_act    = blank ? 7'h00 : hex_decode(upper[3:0]);
    an_act     = DIGITS'(1) << nidx;
    seg_dp_act = |(src_dp & an_act);

    if (xfer) begin
      disp_data_d = shadow_data_q;
      disp_dp_d   = shadow_dp_q;
      pend_d      = 1'b0;
    end
    if (load_i) begin
      shadow_data_d = data_i;
      shadow_dp_d   = dp_i;
      pend_d        = 1'b1;
    end
    if (ce1ms_i) begin
      idx_d    = nidx;
      seg_d    = seg_act ^ SEG_OFF;
      seg_dp_d = seg_dp_act ^ ACTIVE_LOW;
      an_d     = an_act ^ AN_OFF;
      frame_d  = (nidx == '0);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      disp_data_q   <= '0;
      disp_dp_q     <= '0;
      pend_q        <= 1'b0;
      idx_q         <= LAST;
      seg_q         <= SEG_OFF;
      seg_dp_q      <= ACTIVE_LOW;
      an_q          <= AN_OFF;
      frame_q       <= 1'b0;
    end else begin
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      disp_data_q   <= disp_data_d;
      disp_dp_q     <= disp_dp_d;
      pend_q        <= pend_d;
      idx_q         <= idx_d;
      seg_q         <= seg_d;
      seg_dp_q      <= seg_dp_d;
      an_q          <= an_d;
      frame_q       <= frame_d;
    end
  end

  assign seg_o    = seg_q;
  assign seg_dp_o = seg_dp_q;
  assign an_o     = an_q;
  assign pend_o   = pend_q;
  assign frame_o  = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan: a 4-digit active-low instance and an 8-digit
// active-high instance share one clock.
module tb_seg7_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // 4-digit, active-low instance
  logic        rst_a = 1'b1, ce_a = 1'b0, ld_a = 1'b0, blz_a = 1'b0;
  logic [15:0] data_a = '0;
  logic [3:0]  dp_a = '0;
  logic [6:0]  seg_a;
  logic        sdp_a, pend_a, frame_a;
  logic [3:0]  an_a;

  seg7_scan #(.DIGITS(4), .ACTIVE_LOW(1'b1)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .ce1ms_i(ce_a), .load_i(ld_a),
    .data_i(data_a), .dp_i(dp_a), .blank_lz_i(blz_a),
    .seg_o(seg_a), .seg_dp_o(sdp_a), .an_o(an_a), .pend_o(pend_a), .frame_o(frame_a)
  );

  // 8-digit, active-high instance
  logic        rst_b = 1'b1, ce_b = 1'b0, ld_b = 1'b0;
  logic [31:0] data_b = '0;
  logic [7:0]  dp_b = '0;
  logic [6:0]  seg_b;
  logic        sdp_b, pend_b, frame_b;
  logic [7:0]  an_b;

  seg7_scan #(.DIGITS(8), .ACTIVE_LOW(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .ce1ms_i(ce_b), .load_i(ld_b),
    .data_i(data_b), .dp_i(dp_b), .blank_lz_i(1'b0),
    .seg_o(seg_b), .seg_dp_o(sdp_b), .an_o(an_b), .pend_o(pend_b), .frame_o(frame_b)
  );

  int fcnt_b = 0;
  always @(negedge clk) if (frame_b) fcnt_b++;

  typedef struct {
    logic        ld;
    logic [15:0] data;
    logic [3:0]  dp;
    logic        blank;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        sdp;
    logic        frame;
    logic        pend;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_a();
    repeat (3) tick();
    ce_a = 1'b1;
    tick();
    ce_a = 1'b0;
  endtask

  task automatic load_a(input logic [15:0] d, input logic [3:0] p);
    ld_a = 1'b1; data_a = d; dp_a = p;
    tick();
    ld_a = 1'b0;
  endtask

  task automatic strobe_b();
    repeat (3) tick();
    ce_b = 1'b1;
    tick();
    ce_b = 1'b0;
  endtask

  task automatic chk_a(input string tag, input logic [3:0] an, input logic [6:0] seg,
                       input logic sdp, input logic pend);
    chk({tag, " an"},   32'(an_a),   32'(an));
    chk({tag, " seg"},  32'(seg_a),  32'(seg));
    chk({tag, " dp"},   32'(sdp_a),  32'(sdp));
    chk({tag, " pend"}, 32'(pend_a), 32'(pend));
  endtask

  logic [6:0] exp_b0 [8];
  logic [6:0] exp_b1 [8];

  initial begin
    // ld, data, dp, blank, an, seg(active-low), sdp, frame, pend
    vecs[0]  = '{1'b0, 16'h0000, 4'b0000, 1'b0, 4'hE, 7'h40, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 16'h0000, 4'b0000, 1'b0, 4'hD, 7'h40, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 16'h12AF, 4'b0010, 1'b0, 4'hB, 7'h40, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 16'h0000, 4'b0000, 1'b0, 4'h7, 7'h40, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 16'h0000, 4'b0000, 1'b0, 4'hE, 7'h0E, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 16'h0000, 4'b0000, 1'b0, 4'hD, 7'h08, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 16'h0000, 4'b0000, 1'b0, 4'hB, 7'h24, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 16'h0000, 4'b0000, 1'b0, 4'h7, 7'h79, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 16'h0005, 4'b0000, 1'b1, 4'hE, 7'h12, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 16'h0000, 4'b0000, 1'b1, 4'hD, 7'h7F, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 16'h0000, 4'b0000, 1'b1, 4'hB, 7'h7F, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 16'h0000, 4'b0000, 1'b1, 4'h7, 7'h7F, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 16'h0000, 4'b0000, 1'b1, 4'hE, 7'h40, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 16'h0000, 4'b0000, 1'b1, 4'hD, 7'h7F, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 16'h0000, 4'b0000, 1'b1, 4'hB, 7'h7F, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 16'h0000, 4'b0000, 1'b1, 4'h7, 7'h7F, 1'b1, 1'b0, 1'b0};

    // Instance B expectations, digits 0..7, active-high
    exp_b0 = '{7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F};  // 0x89ABCDEF
    exp_b1 = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};  // 0x76543210

    // Reset state
    repeat (2) tick();
    chk("rst an",    32'(an_a),    32'hF);
    chk("rst seg",   32'(seg_a),   32'h7F);
    chk("rst dp",    32'(sdp_a),   32'h1);
    chk("rst pend",  32'(pend_a),  32'h0);
    chk("rst frame", 32'(frame_a), 32'h0);
    chk("rst an_b",  32'(an_b),    32'h00);
    chk("rst seg_b", 32'(seg_b),   32'h00);
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick();

    // Table: optional load before each strobe, then check the updated digit
    for (int i = 0; i < 16; i++) begin
      blz_a = vecs[i].blank;
      if (vecs[i].ld) load_a(vecs[i].data, vecs[i].dp);
      strobe_a();
      chk_a($sformatf("vec%0d", i), vecs[i].an, vecs[i].seg, vecs[i].sdp, vecs[i].pend);
      chk($sformatf("vec%0d frame", i), 32'(frame_a), 32'(vecs[i].frame));
      if (i == 0) begin
        tick();
        chk("frame one-cycle", 32'(frame_a), 32'h0);
      end
    end
    blz_a = 1'b0;

    // Load coinciding with the wrap strobe: old shadow shown, new stays pending
    load_a(16'h1234, 4'b0000);
    chk("pend after load", 32'(pend_a), 32'h1);
    repeat (3) tick();
    ce_a = 1'b1; ld_a = 1'b1; data_a = 16'hBEEF; dp_a = 4'b0000;
    tick();
    ce_a = 1'b0; ld_a = 1'b0;
    chk_a("wrapld d0", 4'hE, 7'h19, 1'b1, 1'b1);
    strobe_a(); chk_a("wrapld d1", 4'hD, 7'h30, 1'b1, 1'b1);
    strobe_a(); chk_a("wrapld d2", 4'hB, 7'h24, 1'b1, 1'b1);
    strobe_a(); chk_a("wrapld d3", 4'h7, 7'h79, 1'b1, 1'b1);
    strobe_a(); chk_a("beef d0",   4'hE, 7'h0E, 1'b1, 1'b0);
    strobe_a(); chk_a("beef d1",   4'hD, 7'h06, 1'b1, 1'b0);
    strobe_a(); chk_a("beef d2",   4'hB, 7'h06, 1'b1, 1'b0);
    strobe_a(); chk_a("beef d3",   4'h7, 7'h03, 1'b1, 1'b0);

    // Strobe held high two cycles: index advances every cycle
    repeat (3) tick();
    ce_a = 1'b1;
    tick();
    chk("ce held 1st an", 32'(an_a), 32'hE);
    tick();
    ce_a = 1'b0;
    chk("ce held 2nd an", 32'(an_a), 32'hD);
    strobe_a();
    chk_a("pre-rst d2", 4'hB, 7'h06, 1'b1, 1'b0);

    // Asynchronous reset while digit 2 is active
    @(negedge clk);
    rst_a = 1'b1;
    #1;
    chk("async rst an",  32'(an_a),  32'hF);
    chk("async rst seg", 32'(seg_a), 32'h7F);
    chk("async rst dp",  32'(sdp_a), 32'h1);
    tick();
    rst_a = 1'b0;
    strobe_a();
    chk_a("post-rst d0", 4'hE, 7'h40, 1'b1, 1'b0);
    chk("post-rst frame", 32'(frame_a), 32'h1);

    // Instance B: 8-digit active-high, two frames covering every hex glyph
    ld_b = 1'b1; data_b = 32'h89ABCDEF; dp_b = 8'h81;
    tick();
    ld_b = 1'b0;
    chk("b pend", 32'(pend_b), 32'h1);
    tick();
    begin
      int f0;
      f0 = fcnt_b;
      for (int k = 0; k < 8; k++) begin
        strobe_b();
        chk($sformatf("b f0 an%0d", k),  32'(an_b),  32'(8'h01 << k));
        chk($sformatf("b f0 seg%0d", k), 32'(seg_b), 32'(exp_b0[k]));
        chk($sformatf("b f0 dp%0d", k),  32'(sdp_b), 32'((k == 0 || k == 7) ? 1 : 0));
        if (k == 0) begin
          ld_b = 1'b1; data_b = 32'h76543210; dp_b = 8'h00;
          tick();
          ld_b = 1'b0;
        end
      end
      repeat (3) tick();
      chk("b frames per 8 strobes", 32'(fcnt_b - f0), 32'd1);
    end
    for (int k = 0; k < 8; k++) begin
      strobe_b();
      chk($sformatf("b f1 seg%0d", k), 32'(seg_b), 32'(exp_b1[k]));
      chk($sformatf("b f1 pend%0d", k), 32'(pend_b), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
